flash_byte_reader: RTL and testbench
====================================

Name: flash_byte_reader

Overview:
- Read-only byte front end for the MAX10 on-chip flash Avalon-MM data port. It sits directly upstream of the internal_flash instance.
- It accepts byte read requests from the CPU-socket bus logic and fetches aligned bursts of 32-bit words into a single-line buffer. It returns the addressed byte.
- Repeat reads within the buffered line are served without touching flash.

Parameters:
- ADDR_W, 12, flash word address width; matches avmm_data_addr.
- BURST_LEN, 4, words per line/burst. Power of two, 1..8. Drives avm_burstcount.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  byte read request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W+2  byte address. Bits [1:0] select the byte within a word.
- flush  in  1  invalidate the line buffer.
- rsp_valid  out  1  one-cycle pulse; rsp_data valid.
- rsp_data  out  8  returned byte.
- avm_addr  out  ADDR_W  word address to flash data port.
- avm_read  out  1  Avalon read command.
- avm_burstcount  out  4  constant BURST_LEN.
- avm_readdata  in  32  flash read data.
- avm_waitrequest  in  1  command stall.
- avm_readdatavalid  in  1  read data strobe.
- hit  out  1  pulses with rsp_valid when the response was a buffer hit.

Behaviour:
- Reset: the following outputs and state are 0:
  - req_ready, rsp_valid, rsp_data, avm_read, avm_addr, hit
  - line valid bit, fill counter, pending-flush flag
  - state = IDLE
- Line tag = req_addr[ADDR_W+1:2+log2(BURST_LEN)]. Line base word = tag concatenated with zeros.
- FSM states: IDLE, ISSUE, FILL, RESPOND.
- IDLE:
  - req_ready = 1.
  - On accept, latch req_addr.
  - Hit (valid && tag match): go to RESPOND. rsp_valid is asserted the cycle after accept, so hit latency = 1 cycle.
  - Miss: go to ISSUE.
- ISSUE:
  - avm_read = 1 and avm_addr = line base word, held stable until avm_waitrequest = 0.
  - Then go to FILL and clear the fill counter. avm_read drops the cycle after acceptance.
- FILL:
  - Each avm_readdatavalid writes avm_readdata into buffer[counter] and increments the counter.
  - When the counter reaches BURST_LEN: set valid (unless pending-flush), record the tag, clear pending-flush, go to RESPOND.
- RESPOND:
  - rsp_valid = 1 for exactly one cycle.
  - rsp_data = byte req_addr[1:0] of the addressed word, little-endian (byte 0 = bits 7:0).
  - hit = 1 only if the request was served from the buffer without a fill.
  - Return to IDLE; req_ready rises the following cycle.
  - Miss latency = 1 (ISSUE) + waitrequest cycles + flash data latency + BURST_LEN beats + 1.
- req_ready = 0 in ISSUE, FILL and RESPOND. One request is outstanding at a time.
- avm_readdatavalid outside FILL is ignored; this covers stray beats after a mid-burst reset.
- flush:
  - In IDLE or RESPOND: valid cleared next cycle.
  - In ISSUE or FILL: the burst completes normally and the outstanding request is still answered. The line is left invalid (pending-flush).
  - flush and an accepted request in the same IDLE cycle: flush wins, so the request is treated as a miss.
- Reset mid-burst: the FSM returns to IDLE immediately and the buffer is invalid. The bench ties the flash IP reset to the same source.
- avm_burstcount = BURST_LEN, zero-extended to 4 bits.

Decomposition:
- Package flash_reader_pkg holds:
  - state enum (IDLE, ISSUE, FILL, RESPOND)
  - FLASH_WORD_W = 32
  - MAX_BURST = 8
  - helper function for line base computation
- One sub-module: flash_line_buffer. It holds BURST_LEN x 32 storage plus valid/tag, exposes a write port indexed by the fill counter, and returns the byte-select read mux.

Test Plan:
1. Cold miss: req_addr=0x0006, flash model returns words 0x44332211, 0x88776655, 0xCCBBAA99, 0x00FFEEDD with 2-cycle waitrequest and 3-cycle latency.
   Required: one avm_read at avm_addr=0x000 with burstcount=4; rsp_data=0x77; hit=0.
2. Hit after fill: req_addr=0x000C, then 0x0001.
   Required: rsp_valid 1 cycle after each accept; rsp_data=0xDD then 0x22; hit=1; no avm_read asserted.
3. Line change: req_addr=0x0010.
   Required: new burst at avm_addr=0x004; later req 0x0000 misses again, with a burst at 0x000.
4. Flush during FILL: assert flush on 2nd readdatavalid beat of a miss to 0x0020.
   Required: response still correct; immediate re-request of 0x0021 issues a new burst (hit=0).
5. Reset mid-burst: reset after 1 beat, then inject 3 stray readdatavalid beats in IDLE.
   Required: all outputs 0; strays ignored; next req to the same line misses and refetches.
6. Back-pressure: hold avm_waitrequest=1 for 10 cycles.
   Required: avm_read and avm_addr stable throughout; req_ready=0 until RESPOND completes.

Source files
------------

// File: rtl/flash_reader_pkg.sv
// Shared definitions for the flash byte reader.
//   state_t          : reader FSM states
//   FLASH_WORD_W     : width of one flash data word
//   MAX_BURST        : largest supported line length in words
//   line_base_word() : clears the word-in-line offset bits of a word address
package flash_reader_pkg;

    localparam int FLASH_WORD_W = 32;
    localparam int MAX_BURST    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        FILL    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    // burst_len is a power of two, so masking the low bits gives the
    // first word of the line containing word_addr.
    function automatic logic [31:0] line_base_word(input logic [31:0] word_addr,
                                                   input int unsigned burst_len);
        logic [31:0] mask;
        mask = ~(32'(burst_len) - 32'd1);
        return word_addr & mask;
    endfunction

endpackage

// File: rtl/flash_line_buffer.sv
// Single-line buffer for the flash byte reader.
//   clock, reset   : system clock, synchronous active-high reset
//   wr_en/wr_idx/wr_data : fill write port, indexed by the fill counter
//   line_done/line_base/line_keep : end of fill; record tag, set valid = line_keep
//   clr_valid      : invalidate the line
//   rd_idx/rd_byte_sel -> rd_byte : byte read mux, little-endian
//   valid, tag     : line state used for hit detection
module flash_line_buffer
    import flash_reader_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BURST_LEN = 4,
    parameter int IDX_W     = 2
)(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [FLASH_WORD_W-1:0] wr_data,
    input  logic                    line_done,
    input  logic [ADDR_W-1:0]       line_base,
    input  logic                    line_keep,
    input  logic                    clr_valid,
    input  logic [IDX_W-1:0]        rd_idx,
    input  logic [1:0]              rd_byte_sel,
    output logic [7:0]              rd_byte,
    output logic                    valid,
    output logic [ADDR_W-1:0]       tag
);

    logic [FLASH_WORD_W-1:0] r_mem [BURST_LEN];
    logic                    r_valid;
    logic [ADDR_W-1:0]       r_tag;
    logic [FLASH_WORD_W-1:0] w_word;

    // Data storage carries no reset; only the valid bit qualifies it.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
        if (line_done) begin
            r_tag <= line_base;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (clr_valid) begin
            r_valid <= 1'b0;
        end else if (line_done) begin
            r_valid <= line_keep;
        end
    end

    assign w_word  = r_mem[rd_idx];
    assign rd_byte = w_word[{rd_byte_sel, 3'b000} +: 8];
    assign valid   = r_valid;
    assign tag     = r_tag;

endmodule

// File: rtl/flash_byte_reader.sv
// Byte read front end for the MAX10 on-chip flash Avalon-MM data port.
// Fetches aligned BURST_LEN-word lines into a one-line buffer and returns the
// addressed byte; repeat reads inside the buffered line skip the flash.
//   clock, reset        : system clock, synchronous active-high reset
//   req_valid/req_ready/req_addr : byte read request (addr[1:0] = byte in word)
//   flush               : invalidate the line buffer
//   rsp_valid/rsp_data/hit : one-cycle response, hit = served from buffer
//   avm_*               : Avalon-MM burst read master toward internal_flash
module flash_byte_reader
    import flash_reader_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BURST_LEN = 4
)(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W+1:0]       req_addr,
    input  logic                    flush,
    output logic                    rsp_valid,
    output logic [7:0]              rsp_data,
    output logic [ADDR_W-1:0]       avm_addr,
    output logic                    avm_read,
    output logic [3:0]              avm_burstcount,
    input  logic [FLASH_WORD_W-1:0] avm_readdata,
    input  logic                    avm_waitrequest,
    input  logic                    avm_readdatavalid,
    output logic                    hit
);

    localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    if (BURST_LEN < 1 || BURST_LEN > MAX_BURST || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst
        $error("flash_byte_reader: BURST_LEN must be a power of two in 1..8");
    end

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W+1:0] r_req_addr;
    logic              r_hit;
    logic              r_req_ready;
    logic              r_pend_flush;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic              w_hit_now;
    logic              w_clr_valid;
    logic              w_wr_en;
    logic              w_fill_done;
    logic              w_line_keep;
    logic [ADDR_W-1:0] w_in_base;
    logic [ADDR_W-1:0] w_cur_base;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [7:0]        w_rd_byte;
    logic              w_buf_valid;
    logic [ADDR_W-1:0] w_buf_tag;

    assign w_in_base  = ADDR_W'(line_base_word(32'(req_addr[ADDR_W+1:2]), BURST_LEN));
    assign w_cur_base = ADDR_W'(line_base_word(32'(r_req_addr[ADDR_W+1:2]), BURST_LEN));
    assign w_rd_idx   = IDX_W'(r_req_addr[ADDR_W+1:2] & ADDR_W'(BURST_LEN - 1));

    // A flush seen at any point of the fill (including the last beat)
    // leaves the freshly fetched line invalid.
    assign w_line_keep = !r_pend_flush && !flush;

    assign req_ready      = r_req_ready;
    assign avm_burstcount = 4'(BURST_LEN);

    flash_line_buffer #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .IDX_W     (IDX_W)
    ) u_line (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (w_wr_en),
        .wr_idx      (r_cnt[IDX_W-1:0]),
        .wr_data     (avm_readdata),
        .line_done   (w_fill_done),
        .line_base   (w_cur_base),
        .line_keep   (w_line_keep),
        .clr_valid   (w_clr_valid),
        .rd_idx      (w_rd_idx),
        .rd_byte_sel (r_req_addr[1:0]),
        .rd_byte     (w_rd_byte),
        .valid       (w_buf_valid),
        .tag         (w_buf_tag)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b0;
            r_hit        <= 1'b0;
            r_cnt        <= '0;
            r_pend_flush <= 1'b0;
        end else begin
            r_state     <= w_next;
            // Registered so it stays low through reset and rises once the
            // FSM is back in IDLE.
            r_req_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_hit <= w_hit_now;
            end
            if (r_state == ISSUE) begin
                r_cnt <= '0;
            end else if (w_wr_en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_fill_done) begin
                r_pend_flush <= 1'b0;
            end else if (flush && (r_state == ISSUE || r_state == FILL)) begin
                r_pend_flush <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_req_addr <= req_addr;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_hit_now   = 1'b0;
        w_clr_valid = 1'b0;
        w_wr_en     = 1'b0;
        w_fill_done = 1'b0;
        avm_read    = 1'b0;
        avm_addr    = '0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        hit         = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_accept    = req_valid && r_req_ready;
                w_clr_valid = flush;
                if (w_accept) begin
                    // A simultaneous flush forces the miss path.
                    if (w_buf_valid && (w_buf_tag == w_in_base) && !flush) begin
                        w_hit_now = 1'b1;
                        w_next    = RESPOND;
                    end else begin
                        // Old line is about to be overwritten.
                        w_clr_valid = 1'b1;
                        w_next      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                avm_read = 1'b1;
                avm_addr = w_cur_base;
                if (!avm_waitrequest) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                if (avm_readdatavalid) begin
                    w_wr_en = 1'b1;
                    if (r_cnt == CNT_W'(BURST_LEN - 1)) begin
                        w_fill_done = 1'b1;
                        w_next      = RESPOND;
                    end
                end
            end
            RESPOND: begin
                rsp_valid   = 1'b1;
                rsp_data    = w_rd_byte;
                hit         = r_hit;
                w_clr_valid = flush;
                w_next      = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_flash_byte_reader.sv
module tb_flash_byte_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [13:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [11:0] avm_addr;
    logic        avm_read;
    logic [3:0]  avm_burstcount;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic        hit;

    int total = 0;
    int bad   = 0;

    int          n_cmd = 0;
    int          n_rsp = 0;
    int          n_rdcyc = 0;
    logic [11:0] last_cmd_addr = '0;
    logic [3:0]  last_bc = '0;
    logic        serve_timeout = 1'b0;
    logic        bp_unstable = 1'b0;

    always #5 clock = ~clock;

    flash_byte_reader #(.ADDR_W(12), .BURST_LEN(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .flush             (flush),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .avm_addr          (avm_addr),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .hit               (hit)
    );

    always @(posedge clock) begin
        if (avm_read === 1'b1 && avm_waitrequest === 1'b0) begin
            n_cmd         <= n_cmd + 1;
            last_cmd_addr <= avm_addr;
            last_bc       <= avm_burstcount;
        end
        if (avm_read === 1'b1) n_rdcyc <= n_rdcyc + 1;
        if (rsp_valid === 1'b1) n_rsp <= n_rsp + 1;
    end

    // Flash contents: words 0..3 fixed; elsewhere byte at byte address b is b ^ 0x80.
    function automatic logic [31:0] flash_word(input int unsigned wa);
        logic [7:0] b0;
        case (wa)
            0: return 32'h44332211;
            1: return 32'h88776655;
            2: return 32'hCCBBAA99;
            3: return 32'h00FFEEDD;
            default: begin
                b0 = 8'(wa * 4);
                return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0} ^ 32'h80808080;
            end
        endcase
    endfunction

    // Flash slave model for one burst.
    task automatic serve(input int wcyc, input int lat, input int nbeats, input int flush_beat);
        int c;
        logic [11:0] a;
        c = 0;
        while (avm_read !== 1'b1 && c < 40) begin
            @(posedge clock); #1; c++;
        end
        if (avm_read !== 1'b1) begin
            serve_timeout = 1'b1;
            return;
        end
        a = avm_addr;
        for (int i = 0; i < wcyc; i++) begin
            @(posedge clock); #1;
            if (avm_read !== 1'b1 || avm_addr !== a) bp_unstable = 1'b1;
        end
        avm_waitrequest = 1'b0;
        @(posedge clock); #1;
        avm_waitrequest = 1'b1;
        for (int i = 1; i < lat; i++) begin
            @(posedge clock); #1;
        end
        for (int i = 0; i < nbeats; i++) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = flash_word(32'(a) + 32'(i));
            if (i + 1 == flush_beat) flush = 1'b1;
            @(posedge clock); #1;
            flush = 1'b0;
        end
        avm_readdatavalid = 1'b0;
    endtask

    task automatic issue_req(input logic [13:0] a, input logic fl);
        int c;
        c = 0;
        while (req_ready !== 1'b1 && c < 50) begin
            @(posedge clock); #1; c++;
        end
        req_valid = 1'b1;
        req_addr  = a;
        flush     = fl;
        @(posedge clock); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic wait_rsp(output logic got, output logic [7:0] d, output logic h,
                            output int lat, output logic leak, output logic multi);
        int c;
        c = 0; got = 1'b0; d = '0; h = 1'b0; lat = 0; leak = 1'b0; multi = 1'b0;
        while (rsp_valid !== 1'b1 && c < 200) begin
            if (req_ready !== 1'b0) leak = 1'b1;
            @(posedge clock); #1; c++;
        end
        if (rsp_valid === 1'b1) begin
            got = 1'b1; d = rsp_data; h = hit; lat = c + 1;
            if (req_ready !== 1'b0) leak = 1'b1;
            @(posedge clock); #1;
            multi = (rsp_valid === 1'b1);
        end
    endtask

    task automatic miss_req(input logic [13:0] a, input logic fl, input int wcyc, input int lat,
                            input int flush_beat, output logic got, output logic [7:0] d,
                            output logic h, output logic leak, output logic multi);
        int l;
        fork
            serve(wcyc, lat, 4, flush_beat);
            begin
                issue_req(a, fl);
                wait_rsp(got, d, h, l, leak, multi);
            end
        join
    endtask

    task automatic test_reset();
        int c;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0; avm_readdata = '0;
        repeat (2) begin @(posedge clock); #1; end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %0b want 0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data: got %0h want 0", rsp_data); end
        total++; if (avm_read !== 1'b0) begin bad++; $display("FAIL reset_avm_read: got %0b want 0", avm_read); end
        total++; if (avm_addr !== 12'h000) begin bad++; $display("FAIL reset_avm_addr: got %0h want 0", avm_addr); end
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %0b want 0", hit); end
        total++; if (avm_burstcount !== 4'd4) begin bad++; $display("FAIL burstcount: got %0d want 4", avm_burstcount); end
        reset = 1'b0;
        c = 0;
        while (req_ready !== 1'b1 && c < 5) begin @(posedge clock); #1; c++; end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %0b want 1", req_ready); end
    endtask

    task automatic test_cold_miss();
        logic got, h, leak, multi; logic [7:0] d; int c0;
        c0 = n_cmd;
        miss_req(14'h0006, 1'b0, 2, 3, 0, got, d, h, leak, multi);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL cold_rsp: got %0b want 1", got); end
        total++; if (d !== 8'h77) begin bad++; $display("FAIL cold_data: got %0h want 77", d); end
        total++; if (h !== 1'b0) begin bad++; $display("FAIL cold_hit: got %0b want 0", h); end
        total++; if (multi !== 1'b0) begin bad++; $display("FAIL cold_pulse: rsp_valid held %0b want 0", multi); end
        total++; if (n_cmd - c0 !== 1) begin bad++; $display("FAIL cold_cmds: got %0d want 1", n_cmd - c0); end
        total++; if (last_cmd_addr !== 12'h000) begin bad++; $display("FAIL cold_addr: got %0h want 0", last_cmd_addr); end
        total++; if (last_bc !== 4'd4) begin bad++; $display("FAIL cold_bc: got %0d want 4", last_bc); end
        total++; if (serve_timeout !== 1'b0) begin bad++; $display("FAIL cold_no_read: timeout %0b want 0", serve_timeout); end
    endtask

    task automatic test_hit();
        logic got, h, leak, multi; logic [7:0] d; int lat, r0;
        r0 = n_rdcyc;
        issue_req(14'h000C, 1'b0);
        wait_rsp(got, d, h, lat, leak, multi);
        total++; if (lat !== 1) begin bad++; $display("FAIL hit1_latency: got %0d want 1", lat); end
        total++; if (d !== 8'hDD) begin bad++; $display("FAIL hit1_data: got %0h want dd", d); end
        total++; if (h !== 1'b1) begin bad++; $display("FAIL hit1_hit: got %0b want 1", h); end
        issue_req(14'h0001, 1'b0);
        wait_rsp(got, d, h, lat, leak, multi);
        total++; if (lat !== 1) begin bad++; $display("FAIL hit2_latency: got %0d want 1", lat); end
        total++; if (d !== 8'h22) begin bad++; $display("FAIL hit2_data: got %0h want 22", d); end
        total++; if (h !== 1'b1) begin bad++; $display("FAIL hit2_hit: got %0b want 1", h); end
        total++; if (n_rdcyc - r0 !== 0) begin bad++; $display("FAIL hit_no_read: read cycles %0d want 0", n_rdcyc - r0); end
    endtask

    task automatic test_line_change();
        logic got, h, leak, multi; logic [7:0] d;
        miss_req(14'h0010, 1'b0, 0, 2, 0, got, d, h, leak, multi);
        total++; if (d !== 8'h90) begin bad++; $display("FAIL line_data: got %0h want 90", d); end
        total++; if (h !== 1'b0) begin bad++; $display("FAIL line_hit: got %0b want 0", h); end
        total++; if (last_cmd_addr !== 12'h004) begin bad++; $display("FAIL line_addr: got %0h want 4", last_cmd_addr); end
        miss_req(14'h0000, 1'b0, 1, 1, 0, got, d, h, leak, multi);
        total++; if (d !== 8'h11) begin bad++; $display("FAIL back_data: got %0h want 11", d); end
        total++; if (h !== 1'b0) begin bad++; $display("FAIL back_hit: got %0b want 0", h); end
        total++; if (last_cmd_addr !== 12'h000) begin bad++; $display("FAIL back_addr: got %0h want 0", last_cmd_addr); end
    endtask

    task automatic test_flush_fill();
        logic got, h, leak, multi; logic [7:0] d; int c0;
        miss_req(14'h0020, 1'b0, 0, 2, 2, got, d, h, leak, multi);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL ffill_rsp: got %0b want 1", got); end
        total++; if (d !== 8'hA0) begin bad++; $display("FAIL ffill_data: got %0h want a0", d); end
        c0 = n_cmd;
        miss_req(14'h0021, 1'b0, 0, 2, 0, got, d, h, leak, multi);
        total++; if (h !== 1'b0) begin bad++; $display("FAIL ffill_rereq_hit: got %0b want 0", h); end
        total++; if (d !== 8'hA1) begin bad++; $display("FAIL ffill_rereq_data: got %0h want a1", d); end
        total++; if (n_cmd - c0 !== 1) begin bad++; $display("FAIL ffill_rereq_cmds: got %0d want 1", n_cmd - c0); end
        total++; if (last_cmd_addr !== 12'h008) begin bad++; $display("FAIL ffill_addr: got %0h want 8", last_cmd_addr); end
    endtask

    task automatic test_reset_mid_burst();
        logic got, h, leak, multi; logic [7:0] d; int r0, q0;
        fork
            serve(0, 1, 1, 0);
            issue_req(14'h0030, 1'b0);
        join
        reset = 1'b1;
        @(posedge clock); #1;
        total++; if ({req_ready, rsp_valid, avm_read, hit} !== 4'b0000) begin bad++; $display("FAIL midrst_ctrl: got %b want 0000", {req_ready, rsp_valid, avm_read, hit}); end
        total++; if ({rsp_data, avm_addr} !== 20'h0) begin bad++; $display("FAIL midrst_data: got %0h want 0", {rsp_data, avm_addr}); end
        reset = 1'b0;
        r0 = n_rsp; q0 = n_rdcyc;
        avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF;
        repeat (3) begin @(posedge clock); #1; end
        avm_readdatavalid = 1'b0;
        @(posedge clock); #1;
        total++; if (n_rsp - r0 !== 0) begin bad++; $display("FAIL stray_rsp: got %0d want 0", n_rsp - r0); end
        total++; if (n_rdcyc - q0 !== 0) begin bad++; $display("FAIL stray_read: got %0d want 0", n_rdcyc - q0); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stray_idle: ready %0b want 1", req_ready); end
        miss_req(14'h0031, 1'b0, 0, 2, 0, got, d, h, leak, multi);
        total++; if (h !== 1'b0) begin bad++; $display("FAIL midrst_refetch_hit: got %0b want 0", h); end
        total++; if (d !== 8'hB1) begin bad++; $display("FAIL midrst_refetch_data: got %0h want b1", d); end
        total++; if (last_cmd_addr !== 12'h00C) begin bad++; $display("FAIL midrst_addr: got %0h want c", last_cmd_addr); end
    endtask

    task automatic test_back_pressure();
        logic got, h, leak, multi; logic [7:0] d;
        bp_unstable = 1'b0;
        miss_req(14'h0044, 1'b0, 10, 2, 0, got, d, h, leak, multi);
        total++; if (bp_unstable !== 1'b0) begin bad++; $display("FAIL bp_stable: unstable %0b want 0", bp_unstable); end
        total++; if (leak !== 1'b0) begin bad++; $display("FAIL bp_ready_low: leak %0b want 0", leak); end
        total++; if (d !== 8'hC4) begin bad++; $display("FAIL bp_data: got %0h want c4", d); end
        total++; if (last_cmd_addr !== 12'h010) begin bad++; $display("FAIL bp_addr: got %0h want 10", last_cmd_addr); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back: got %0b want 1", req_ready); end
    endtask

    task automatic test_flush_idle();
        logic got, h, leak, multi; logic [7:0] d; int lat, c0;
        issue_req(14'h0045, 1'b0);
        wait_rsp(got, d, h, lat, leak, multi);
        total++; if (h !== 1'b1) begin bad++; $display("FAIL fidle_prehit: got %0b want 1", h); end
        total++; if (d !== 8'hC5) begin bad++; $display("FAIL fidle_predata: got %0h want c5", d); end
        c0 = n_cmd;
        miss_req(14'h0046, 1'b1, 0, 2, 0, got, d, h, leak, multi);
        total++; if (h !== 1'b0) begin bad++; $display("FAIL fidle_hit: got %0b want 0", h); end
        total++; if (d !== 8'hC6) begin bad++; $display("FAIL fidle_data: got %0h want c6", d); end
        total++; if (n_cmd - c0 !== 1) begin bad++; $display("FAIL fidle_cmds: got %0d want 1", n_cmd - c0); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_line_change();
        test_flush_fill();
        test_reset_mid_burst();
        test_back_pressure();
        test_flush_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
